multi_ball_renderer: RTL
========================

MULTI_BALL_RENDERER -- requirements
Module: multi_ball_renderer

Interface
REQ-001 Parameters (name, default, meaning); every value is an elaboration-time constant:
- NUM_BALLS, 8, number of ball slots; power of 2, range 2..16.
- COORD_W, 10, screen coordinate width.
- RADIUS_W, 6, radius width.
- AW, $clog2(NUM_BALLS)+2, Avalon word-address width.
REQ-002 Ports (name, direction, width, meaning):
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- avl_address  in  AW  word address.
- avl_write  in  1  write strobe.
- avl_writedata  in  32  write data.
- avl_read  in  1  read strobe.
- avl_readdata  out  32  read data.
- VGA_VS  in  1  vertical sync, active low, generated in the Clk domain.
- DrawX  in  COORD_W  current pixel x.
- DrawY  in  COORD_W  current pixel y.
- is_ball  out  1  pixel lies inside an enabled ball.
- ball_id  out  $clog2(NUM_BALLS)  index of the hit ball.
REQ-003 Clocking and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n).

Function
REQ-004 Address map, with addr[AW-1]=0 selecting ball space:
- addr[AW-2:1] = ball index.
- addr[0]=0 is POS: x in [9:0], y in [25:16].
- addr[0]=1 is SIZE: radius in [5:0], enable in [31].
REQ-005 Address map, with addr[AW-1]=1 selecting control space; only offset 0 is decoded:
- Write: bit0 = 1 sets commit_pending.
- Read STATUS: bit0 = commit_pending, [15:8] = frame_cnt.
- Unused bits read as 0.
REQ-006 Writes land in a shadow register bank one cycle after avl_write is sampled.
REQ-007 Reads return shadow contents or STATUS on avl_readdata exactly 1 cycle after avl_read; avl_readdata holds its value otherwise.
REQ-008 Reads of undecoded control addresses return 0; writes to them are ignored.
REQ-009 Frame edge: VGA_VS is registered once; vs_fall = previous value 1 and current value 0.
REQ-010 On vs_fall:
- frame_cnt increments and wraps from 255 to 0.
- If registered commit_pending=1, the entire shadow bank copies to the active bank in one cycle and commit_pending clears.
REQ-011 Simultaneous events at a vs_fall copy:
- A shadow write in the copy cycle does not reach the active bank; the copy takes the pre-write shadow value.
- A commit write in the copy cycle leaves commit_pending=1 for the next frame.
REQ-012 The hit test uses only the active bank, so ball geometry never changes mid-frame.
REQ-013 Hit pipeline, 3 Clk fixed latency, no stall:
- S1: dx = DrawX - x and dy = DrawY - y, each signed COORD_W+1 bits.
- S2: d2 = dx*dx + dy*dy, unsigned 2*COORD_W+1 bits; r2 = r*r.
- S3: hit[i] = enable[i] && (d2 <= r2).
REQ-014 is_ball = OR of all hit[i].
REQ-015 ball_id = lowest index i with hit[i]=1, or 0 when there is no hit.
REQ-016 Boundary conditions:
- d2 == r2 counts as a hit.
- radius 0 with enable 1 hits only the exact centre pixel.
- Balls partly off-screen need no special handling.
- enable 0 never hits.
- No arithmetic wraps inside the pipeline.

Reset
REQ-017 While Reset_n=0, the following are 0: shadow bank, active bank, commit_pending, frame_cnt, all pipeline registers, avl_readdata, is_ball, ball_id.
REQ-018 Reset asserted mid-operation clears state within the same cycle; it discards any pending commit and any in-flight pixels.
REQ-019 After Reset_n rises, is_ball stays 0 until software enables a ball and commits it.

Structure
REQ-020 Package gravsim_pkg shall hold:
- the COORD_W and RADIUS_W defaults;
- ball_t (x, y, radius, enable);
- the POS, SIZE and CTRL field constants;
- the STATUS bit positions.
REQ-021 Sub-module ball_hit_lane, one instance per ball, implements pipeline stages S1–S3 for one ball_t.
REQ-022 Top level contains:
- the register banks;
- Avalon decode;
- vs_fall detection;
- frame_cnt;
- the priority encoder, registered together with the S3 OR.

Verification
REQ-023 The bench shall cover these directed scenarios:
- Reset: after reset, sweep DrawX/DrawY → is_ball=0 throughout, STATUS=0.
- Single ball: ball 2 at (100,50), r=5, enable, commit, pulse VGA_VS low → DrawX=105,DrawY=50 gives is_ball=1, ball_id=2, 3 cycles later; (106,50) → is_ball=0.
- Overlap priority: balls 1 and 5 both cover (200,200) → ball_id=1; disable ball 1 and commit → ball_id=5 from the next frame.
- No tearing: rewrite ball 0 position without commit → active geometry unchanged across vs_fall; commit write then vs_fall → new position is used.
- Same-cycle collision: shadow write and copy coincide → the old value becomes active; the new value becomes active at the following committed vs_fall.
- Counter and reset: 256 vs_fall edges → frame_cnt returns to 0; Reset_n pulse mid-frame → outputs 0 immediately and commit_pending=0.

Source files
------------

// File: rtl/gravsim_pkg.sv
// gravsim_pkg
//   Shared types and constants for the multi-ball renderer.
//   - COORD_W_DEF / RADIUS_W_DEF : default coordinate and radius widths
//   - ball_t                     : one ball slot (x, y, radius, enable)
//   - POS / SIZE / CTRL fields   : bit positions of the Avalon register fields
//   - STATUS fields              : bit positions inside the STATUS word
//   - pack_pos / pack_size       : build the 32-bit read-back words of a slot
package gravsim_pkg;

  localparam int COORD_W_DEF  = 10;
  localparam int RADIUS_W_DEF = 6;

  typedef struct packed {
    logic                    enable;
    logic [RADIUS_W_DEF-1:0] radius;
    logic [COORD_W_DEF-1:0]  y;
    logic [COORD_W_DEF-1:0]  x;
  } ball_t;

  // Ball-space word select (addr[0])
  localparam logic AVL_FIELD_POS  = 1'b0;
  localparam logic AVL_FIELD_SIZE = 1'b1;

  // POS word
  localparam int POS_X_LSB = 0;
  localparam int POS_Y_LSB = 16;

  // SIZE word
  localparam int SIZE_RADIUS_LSB = 0;
  localparam int SIZE_ENABLE_BIT = 31;

  // CTRL write word
  localparam int CTRL_COMMIT_BIT = 0;

  // STATUS read word
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_FRAME_LSB   = 8;
  localparam int STATUS_FRAME_W     = 8;

  function automatic logic [31:0] pack_pos(input ball_t b);
    logic [31:0] w;
    w = '0;
    w[POS_X_LSB +: COORD_W_DEF] = b.x;
    w[POS_Y_LSB +: COORD_W_DEF] = b.y;
    return w;
  endfunction

  function automatic logic [31:0] pack_size(input ball_t b);
    logic [31:0] w;
    w = '0;
    w[SIZE_RADIUS_LSB +: RADIUS_W_DEF] = b.radius;
    w[SIZE_ENABLE_BIT]                 = b.enable;
    return w;
  endfunction

endpackage

// File: rtl/ball_hit_lane.sv
// ball_hit_lane
//   Hit-test pipeline for one ball slot. Two register stages here plus a
//   combinational compare; the top registers the OR / priority result, which
//   gives the 3-cycle DrawX/DrawY -> is_ball latency.
// Ports:
//   Clk      - system clock
//   Reset_n  - asynchronous active-low reset
//   ball     - active-bank geometry of this slot
//   DrawX/Y  - current pixel
//   hit      - combinational: pixel issued two cycles ago lies inside ball
module ball_hit_lane
  import gravsim_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int RADIUS_W = RADIUS_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  ball_t              ball,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               hit
);

  localparam int D2_W  = 2*COORD_W + 1;
  localparam int R2_W  = 2*RADIUS_W;
  localparam int CMP_W = (D2_W > R2_W) ? D2_W : R2_W;

  logic [COORD_W-1:0]  ball_x;
  logic [COORD_W-1:0]  ball_y;
  logic [RADIUS_W-1:0] ball_r;

  // S1: only the square of dx/dy is ever used, so the stage keeps the
  // magnitude; it is exactly representable in COORD_W bits and cannot wrap.
  logic [COORD_W-1:0]  adx_next, ady_next;
  logic [COORD_W-1:0]  adx_reg, ady_reg;
  logic [RADIUS_W-1:0] r_s1_reg;
  logic                en_s1_reg;

  // S2
  logic [D2_W-1:0] d2_next, d2_reg;
  logic [R2_W-1:0] r2_next, r2_reg;
  logic            en_s2_reg;

  assign ball_x = COORD_W'(ball.x);
  assign ball_y = COORD_W'(ball.y);
  assign ball_r = RADIUS_W'(ball.radius);

  always_comb begin
    adx_next = (DrawX >= ball_x) ? (DrawX - ball_x) : (ball_x - DrawX);
    ady_next = (DrawY >= ball_y) ? (DrawY - ball_y) : (ball_y - DrawY);
  end

  always_comb begin
    d2_next = D2_W'(adx_reg) * D2_W'(adx_reg) + D2_W'(ady_reg) * D2_W'(ady_reg);
    r2_next = R2_W'(r_s1_reg) * R2_W'(r_s1_reg);
  end

  // Radius and enable travel with the pixel so that an active-bank copy
  // landing mid-pipeline cannot mix old and new geometry for one pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      adx_reg   <= '0;
      ady_reg   <= '0;
      r_s1_reg  <= '0;
      en_s1_reg <= 1'b0;
      d2_reg    <= '0;
      r2_reg    <= '0;
      en_s2_reg <= 1'b0;
    end else begin
      adx_reg   <= adx_next;
      ady_reg   <= ady_next;
      r_s1_reg  <= ball_r;
      en_s1_reg <= ball.enable;
      d2_reg    <= d2_next;
      r2_reg    <= r2_next;
      en_s2_reg <= en_s1_reg;
    end
  end

  // S3: boundary (d2 == r2) counts as inside
  assign hit = en_s2_reg && (CMP_W'(d2_reg) <= CMP_W'(r2_reg));

endmodule

// File: rtl/multi_ball_renderer.sv
// multi_ball_renderer
//   Draws up to NUM_BALLS filled circles. Software writes geometry into a
//   shadow bank over Avalon-MM and requests a commit; the shadow bank is
//   copied to the active bank on the next falling edge of VGA_VS so the
//   picture never tears. The hit test runs against the active bank only.
// Ports:
//   Clk, Reset_n           - clock, asynchronous active-low reset
//   avl_address/write/...  - Avalon-MM slave (1-cycle registered reads)
//   VGA_VS                 - vertical sync (active low, Clk domain)
//   DrawX, DrawY           - current pixel
//   is_ball, ball_id       - hit flag and lowest hit index, 3 cycles later
module multi_ball_renderer
  import gravsim_pkg::*;
#(
  parameter int NUM_BALLS = 8,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int RADIUS_W  = RADIUS_W_DEF,
  parameter int AW        = $clog2(NUM_BALLS) + 2
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [AW-1:0]                avl_address,
  input  logic                         avl_write,
  input  logic [31:0]                  avl_writedata,
  input  logic                         avl_read,
  output logic [31:0]                  avl_readdata,
  input  logic                         VGA_VS,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  output logic                         is_ball,
  output logic [$clog2(NUM_BALLS)-1:0] ball_id
);

  localparam int ID_W = $clog2(NUM_BALLS);

  // ---------------------------------------------------------------- decode
  logic            ctrl_sel;
  logic            ctrl_off0;
  logic [ID_W-1:0] avl_idx;
  logic            avl_field;
  logic            ball_wr;
  logic            commit_req;

  assign ctrl_sel   = avl_address[AW-1];
  assign ctrl_off0  = (avl_address[AW-2:0] == '0);
  assign avl_idx    = ID_W'(avl_address[AW-2:1]);
  assign avl_field  = avl_address[0];
  assign ball_wr    = avl_write && !ctrl_sel;
  assign commit_req = avl_write && ctrl_sel && ctrl_off0 &&
                      avl_writedata[CTRL_COMMIT_BIT];

  // Only some write-data bits are decoded; fold the rest into a sink.
  logic wdata_unused;
  assign wdata_unused = ^avl_writedata;

  // ------------------------------------------------------- frame control
  logic                      vs_reg;
  logic                      vs_fall;
  logic                      commit_pending_reg, commit_pending_next;
  logic [STATUS_FRAME_W-1:0] frame_cnt_reg;
  logic                      copy_en;

  assign vs_fall = vs_reg && !VGA_VS;
  assign copy_en = vs_fall && commit_pending_reg;

  // A commit written in the copy cycle re-arms for the next frame.
  always_comb begin
    commit_pending_next = commit_pending_reg;
    if (copy_en)
      commit_pending_next = 1'b0;
    if (commit_req)
      commit_pending_next = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_reg             <= 1'b0;
      commit_pending_reg <= 1'b0;
      frame_cnt_reg      <= '0;
    end else begin
      vs_reg             <= VGA_VS;
      commit_pending_reg <= commit_pending_next;
      if (vs_fall)
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  // ------------------------------------------------ register banks + lanes
  ball_t                shadow_bank [NUM_BALLS];
  ball_t                active_bank [NUM_BALLS];
  logic [NUM_BALLS-1:0] hit;

  for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
    ball_t shadow_reg;
    ball_t active_reg;
    logic  slot_wr;

    assign slot_wr = ball_wr && (avl_idx == ID_W'(gi));

    // Copy uses the current shadow value, so a write in the same cycle
    // only reaches the shadow bank.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        shadow_reg <= '0;
        active_reg <= '0;
      end else begin
        if (copy_en)
          active_reg <= shadow_reg;
        if (slot_wr) begin
          if (avl_field == AVL_FIELD_POS) begin
            shadow_reg.x <= avl_writedata[POS_X_LSB +: COORD_W_DEF];
            shadow_reg.y <= avl_writedata[POS_Y_LSB +: COORD_W_DEF];
          end else begin
            shadow_reg.radius <= avl_writedata[SIZE_RADIUS_LSB +: RADIUS_W_DEF];
            shadow_reg.enable <= avl_writedata[SIZE_ENABLE_BIT];
          end
        end
      end
    end

    assign shadow_bank[gi] = shadow_reg;
    assign active_bank[gi] = active_reg;

    ball_hit_lane #(
      .COORD_W  (COORD_W),
      .RADIUS_W (RADIUS_W)
    ) u_lane (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .ball    (active_bank[gi]),
      .DrawX   (DrawX),
      .DrawY   (DrawY),
      .hit     (hit[gi])
    );
  end

  // ------------------------------------------------------------- readback
  logic [31:0] readdata_reg, readdata_next;

  always_comb begin
    readdata_next = '0;
    if (!ctrl_sel) begin
      if (avl_field == AVL_FIELD_SIZE)
        readdata_next = pack_size(shadow_bank[avl_idx]);
      else
        readdata_next = pack_pos(shadow_bank[avl_idx]);
    end else if (ctrl_off0) begin
      readdata_next[STATUS_PENDING_BIT]                  = commit_pending_reg;
      readdata_next[STATUS_FRAME_LSB +: STATUS_FRAME_W] = frame_cnt_reg;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      readdata_reg <= '0;
    else if (avl_read)
      readdata_reg <= readdata_next;
  end

  assign avl_readdata = readdata_reg;

  // ---------------------------------------------------------- output stage
  logic            is_ball_reg, is_ball_next;
  logic [ID_W-1:0] ball_id_reg, ball_id_next;

  // Scan from the top so the lowest hit index is the one left standing.
  always_comb begin
    is_ball_next = |hit;
    ball_id_next = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit[i])
        ball_id_next = ID_W'(i);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_ball_reg <= 1'b0;
      ball_id_reg <= '0;
    end else begin
      is_ball_reg <= is_ball_next;
      ball_id_reg <= ball_id_next;
    end
  end

  assign is_ball = is_ball_reg;
  assign ball_id = ball_id_reg;

endmodule
